ahbl_slave_mem: RTL and testbench

AHB-Lite responder with on-chip word memory, programmable wait states and ERROR responses. It is the slave-side counterpart of the team's AHB-Lite master BFM. It sits on one HSEL slot of the BFM test fabric, so master-driven vector scripts have a deterministic, checkable target. Reads, writes, byte/halfword lanes, stall insertion and two-cycle error protocol are modelled cycle-accurately.

---
 rtl/ahbl_pkg.sv | 25 ++
 rtl/ahbl_slave_mem_if.sv | 34 +++
 rtl/ahbl_lane_dec.sv | 36 +++
 rtl/ahbl_slave_mem.sv | 141 ++++++++++++++
 tb/tb_ahbl_slave_mem.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ahbl_pkg.sv
// Purpose: shared AHB-Lite encodings and responder state enum.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ahbl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

endpackage

// File: rtl/ahbl_slave_mem_if.sv
// Purpose: AHB-Lite slot bundle between a master/fabric and one responder.
// Latency: n/a (wires only).
// Backpressure: HREADYOUT from the slave, HREADY is the fabric-muxed ready.
// Ports: HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA/HREADY
//        driven by the master side; HREADYOUT/HRESP/HRDATA driven by the slave.
interface ahbl_slave_mem_if;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
               HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK,
               HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );

endinterface

// File: rtl/ahbl_lane_dec.sv
// Purpose: map HSIZE + HADDR[1:0] to little-endian byte-lane enables and an alignment error.
// Latency: combinational.
// Backpressure: none.
// Ports: size_i (HSIZE), addr_i (HADDR[1:0]) -> lanes_o (4-bit enable), align_err_o.
module ahbl_lane_dec
    import ahbl_pkg::*;
(
    input  logic [2:0] size_i,
    input  logic [1:0] addr_i,
    output logic [3:0] lanes_o,
    output logic       align_err_o
);

    always_comb begin
        lanes_o     = 4'b0000;
        align_err_o = 1'b0;
        case (size_i)
            HSIZE_BYTE: begin
                lanes_o = 4'b0001 << addr_i;
            end
            HSIZE_HALF: begin
                lanes_o     = addr_i[1] ? 4'b1100 : 4'b0011;
                align_err_o = addr_i[0];
            end
            HSIZE_WORD: begin
                lanes_o     = 4'b1111;
                align_err_o = |addr_i;
            end
            default: begin
                // Illegal sizes are flagged by the caller; no lanes enabled.
                lanes_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/ahbl_slave_mem.sv
// Purpose: AHB-Lite responder over an on-chip word memory with wait states and ERROR responses.
// Latency: OKAY data phase = WAIT_STATES low cycles + 1 ready cycle; ERROR = 2 cycles.
// Backpressure: HREADYOUT low during wait states and ERR1; no accept unless HREADY is high.
// Ports: HCLK, HRESETN (async active-low), bus (ahbl_slave_mem_if.slave).
module ahbl_slave_mem
    import ahbl_pkg::*;
#(
    parameter int MEM_AW      = 8,
    parameter int WAIT_STATES = 0,
    parameter int DEC_AW      = 20,
    parameter int TPD         = 1
) (
    input  logic            HCLK,
    input  logic            HRESETN,
    ahbl_slave_mem_if.slave bus
);

    localparam int         DEPTH   = 1 << MEM_AW;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              hreadyout_q;
    logic              hresp_q;
    logic              act_q;      // a legal transfer owns the current data phase
    logic              write_q;
    logic [MEM_AW-1:0] idx_q;
    logic [3:0]        lanes_q;

    logic [31:0] mem [DEPTH];

    logic       accept;
    logic       range_err;
    logic       size_err;
    logic       align_err;
    logic       illegal;
    logic [3:0] lanes;
    logic       final_cycle;

    ahbl_lane_dec u_lane_dec (
        .size_i      (bus.HSIZE),
        .addr_i      (bus.HADDR[1:0]),
        .lanes_o     (lanes),
        .align_err_o (align_err)
    );

    // NONSEQ and SEQ both carry HTRANS[1]; IDLE/BUSY never start an access.
    assign accept    = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign range_err = |bus.HADDR[DEC_AW-1:MEM_AW+2];
    assign size_err  = (bus.HSIZE > HSIZE_WORD);
    assign illegal   = range_err | size_err | align_err;

    // Last cycle of a legal data phase: the write commits on the edge closing it,
    // and read data is presented during it.
    assign final_cycle = act_q & hreadyout_q;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            act_q       <= 1'b0;
            write_q     <= 1'b0;
            idx_q       <= '0;
            lanes_q     <= 4'b0000;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    // Loaded with WAIT_STATES; the cycle holding 1 is the last low one.
                    if (cnt_q == 4'd1) begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                    end
                    cnt_q <= cnt_q - 4'd1;
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    // ST_IDLE and ST_ERR2 both drive HREADYOUT high, so a
                    // pipelined address phase may be taken here.
                    if (accept && illegal) begin
                        state_q     <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                        act_q       <= 1'b0;
                        cnt_q       <= 4'd0;
                    end else if (accept) begin
                        act_q   <= 1'b1;
                        write_q <= bus.HWRITE;
                        idx_q   <= bus.HADDR[MEM_AW+1:2];
                        lanes_q <= lanes;
                        hresp_q <= HRESP_OKAY;
                        if (WAIT_STATES > 0) begin
                            state_q     <= ST_WAIT;
                            hreadyout_q <= 1'b0;
                            cnt_q       <= WS_LOAD;
                        end else begin
                            state_q     <= ST_IDLE;
                            hreadyout_q <= 1'b1;
                            cnt_q       <= 4'd0;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                        act_q       <= 1'b0;
                        cnt_q       <= 4'd0;
                    end
                end
            endcase
        end
    end

    // Memory is deliberately not reset. Reset clears act_q asynchronously,
    // which is what drops a write still waiting for its final cycle.
    always_ff @(posedge HCLK) begin
        if (final_cycle && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Asynchronous read so a read pipelined right behind a zero-wait write to
    // the same word sees the value committed on the edge that accepted it.
    assign bus.HRDATA    = (final_cycle && !write_q) ? mem[idx_q] : 32'h0;
    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;

    // Inputs the responder intentionally ignores, plus the simulation-only delay.
    logic unused_ok;
    assign unused_ok = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HADDR[31:DEC_AW],
                         bus.HTRANS[0], (TPD != 0)};

endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Purpose: directed self-checking bench for ahbl_slave_mem (zero-wait and 3-wait instances).
// Latency: n/a.
// Backpressure: driver waits on the selected instance's HREADYOUT before each accept.
module tb_ahbl_slave_mem;
    import ahbl_pkg::*;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    logic        rst0_n, rst3_n;
    logic        sel;            // 0 -> zero-wait instance, 1 -> 3-wait instance
    logic        hsel, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata;
    logic [31:0] nxt_wdata;

    ahbl_slave_mem_if bus0 ();
    ahbl_slave_mem_if bus3 ();

    assign bus0.HSEL      = hsel & ~sel;
    assign bus3.HSEL      = hsel & sel;
    assign bus0.HADDR     = haddr;
    assign bus3.HADDR     = haddr;
    assign bus0.HTRANS    = htrans;
    assign bus3.HTRANS    = htrans;
    assign bus0.HWRITE    = hwrite;
    assign bus3.HWRITE    = hwrite;
    assign bus0.HSIZE     = hsize;
    assign bus3.HSIZE     = hsize;
    assign bus0.HBURST    = 3'd0;
    assign bus3.HBURST    = 3'd0;
    assign bus0.HPROT     = 4'd0;
    assign bus3.HPROT     = 4'd0;
    assign bus0.HMASTLOCK = 1'b0;
    assign bus3.HMASTLOCK = 1'b0;
    assign bus0.HWDATA    = hwdata;
    assign bus3.HWDATA    = hwdata;
    assign bus0.HREADY    = bus0.HREADYOUT;
    assign bus3.HREADY    = bus3.HREADYOUT;

    ahbl_slave_mem #(.MEM_AW(8), .WAIT_STATES(0), .DEC_AW(20), .TPD(1)) dut0 (
        .HCLK    (HCLK),
        .HRESETN (rst0_n),
        .bus     (bus0)
    );

    ahbl_slave_mem #(.MEM_AW(8), .WAIT_STATES(3), .DEC_AW(20), .TPD(1)) dut3 (
        .HCLK    (HCLK),
        .HRESETN (rst3_n),
        .bus     (bus3)
    );

    logic        ry, rsp;
    logic [31:0] rdata;
    assign ry    = sel ? bus3.HREADYOUT : bus0.HREADYOUT;
    assign rsp   = sel ? bus3.HRESP     : bus0.HRESP;
    assign rdata = sel ? bus3.HRDATA    : bus0.HRDATA;

    typedef struct {
        int          ws;
        logic        resp;
        logic [31:0] rd;
    } exp_t;

    exp_t exp_q[$];
    int   checks  = 0;
    int   errors  = 0;
    int   low_cnt = 0;

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Scoreboard: each accepted transfer's data phase is checked at negedges.
    always @(negedge HCLK) begin
        if (exp_q.size() > 0) begin
            if (!ry) begin
                low_cnt++;
                checks++;
                if (rsp !== exp_q[0].resp) fail("resp_during_wait", rsp, exp_q[0].resp);
                checks++;
                if (rdata !== 32'h0) fail("rdata_during_wait", rdata, 32'h0);
            end else begin
                checks++;
                if (rsp !== exp_q[0].resp) fail("resp_final", rsp, exp_q[0].resp);
                checks++;
                if (rdata !== exp_q[0].rd) fail("rdata_final", rdata, exp_q[0].rd);
                checks++;
                if (low_cnt !== exp_q[0].ws) fail("low_cycles", low_cnt, exp_q[0].ws);
                low_cnt = 0;
                void'(exp_q.pop_front());
            end
        end
    end

    // Called just after a posedge. Drives the previous transfer's write data and
    // this address phase, then waits (bounded) for the edge that accepts it.
    task automatic issue(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                         input logic [2:0] sz, input logic [31:0] wd,
                         input int ws, input logic resp, input logic [31:0] rd);
        bit   got;
        exp_t e;
        hwdata = nxt_wdata;
        hsel   = 1'b1;
        htrans = tr;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
        got    = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge HCLK);
            got = ry;
            @(posedge HCLK);
        end
        #1;
        checks++;
        if (got !== 1'b1) fail("accept_timeout", got, 1'b1);
        if (tr[1]) begin
            e.ws   = ws;
            e.resp = resp;
            e.rd   = rd;
            exp_q.push_back(e);
        end
        nxt_wdata = wd;
    endtask

    task automatic idle();
        issue(HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h0);
        hsel = 1'b0;
        checks++;
        if (exp_q.size() !== 0) fail("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
        hsize = HSIZE_WORD; haddr = 32'h0; hwdata = 32'h0; nxt_wdata = 32'h0;
        rst0_n = 1'b0; rst3_n = 1'b0;
        repeat (3) @(negedge HCLK);
        checks++;
        if (bus0.HREADYOUT !== 1'b1) fail("rst_hreadyout0", bus0.HREADYOUT, 1'b1);
        checks++;
        if (bus0.HRESP !== 1'b0) fail("rst_hresp0", bus0.HRESP, 1'b0);
        checks++;
        if (bus0.HRDATA !== 32'h0) fail("rst_hrdata0", bus0.HRDATA, 32'h0);
        checks++;
        if (bus3.HREADYOUT !== 1'b1) fail("rst_hreadyout3", bus3.HREADYOUT, 1'b1);
        checks++;
        if (bus3.HRESP !== 1'b0) fail("rst_hresp3", bus3.HRESP, 1'b0);
        checks++;
        if (bus3.HRDATA !== 32'h0) fail("rst_hrdata3", bus3.HRDATA, 32'h0);
        rst0_n = 1'b1; rst3_n = 1'b1;
        @(posedge HCLK); #1;

        // Zero-wait word write then back-to-back read of the same word.
        issue(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 0, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'hDEADBEEF);
        idle();

        // Byte and halfword lanes; unused lanes carry junk that must be masked.
        issue(HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b1, 32'h22, HSIZE_BYTE, 32'hFFA5FFFF, 0, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_HALF, 32'hEEEE1234, 0, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h00A51234);
        idle();

        // Out-of-range write aliases onto word 0 if not blocked.
        issue(HTRANS_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'hCAFEF00D, 0, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b1, 32'h400, HSIZE_WORD, 32'h12345678, 1, HRESP_ERROR, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'hCAFEF00D);
        idle();

        // Misalignment, illegal size, top decoded bit, undecoded alias.
        issue(HTRANS_NONSEQ, 1'b0, 32'h2, HSIZE_WORD, 32'h0, 1, HRESP_ERROR, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h10, 3'd3, 32'h0, 1, HRESP_ERROR, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h21, HSIZE_HALF, 32'h0, 1, HRESP_ERROR, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'hDEADBEEF);
        issue(HTRANS_NONSEQ, 1'b0, 32'h80010, HSIZE_WORD, 32'h0, 1, HRESP_ERROR, 32'h0);
        issue(HTRANS_SEQ, 1'b0, 32'h100010, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'hDEADBEEF);
        issue(HTRANS_NONSEQ, 1'b0, 32'h23, HSIZE_BYTE, 32'h0, 0, HRESP_OKAY, 32'h00A51234);
        idle();

        // BUSY while selected: zero-wait OKAY, no memory access.
        issue(HTRANS_BUSY, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 0, HRESP_OKAY, 32'h0);
        @(negedge HCLK);
        checks++;
        if (ry !== 1'b1) fail("busy_ready", ry, 1'b1);
        checks++;
        if (rsp !== 1'b0) fail("busy_resp", rsp, 1'b0);
        checks++;
        if (rdata !== 32'h0) fail("busy_rdata", rdata, 32'h0);
        // NONSEQ with HSEL low: not accepted.
        hsel = 1'b0; htrans = HTRANS_NONSEQ; hwrite = 1'b0; haddr = 32'h10;
        @(posedge HCLK); #1;
        htrans = HTRANS_IDLE;
        @(negedge HCLK);
        checks++;
        if (rdata !== 32'h0) fail("unsel_rdata", rdata, 32'h0);
        checks++;
        if (ry !== 1'b1) fail("unsel_ready", ry, 1'b1);
        @(posedge HCLK); #1;

        // Three-wait instance.
        sel = 1'b1;
        @(posedge HCLK); #1;
        issue(HTRANS_NONSEQ, 1'b1, 32'h0, HSIZE_WORD, 32'h5A5A5A5A, 3, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 3, HRESP_OKAY, 32'h5A5A5A5A);
        issue(HTRANS_NONSEQ, 1'b1, 32'h30, HSIZE_WORD, 32'h11111111, 3, HRESP_OKAY, 32'h0);
        issue(HTRANS_NONSEQ, 1'b1, 32'h400, HSIZE_WORD, 32'h99999999, 1, HRESP_ERROR, 32'h0);
        idle();

        // Reset in the second wait cycle of a write to 0x30.
        nxt_wdata = 32'h0;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h30; hsize = HSIZE_WORD;
        @(posedge HCLK); #1;
        hwdata = 32'h22222222; htrans = HTRANS_IDLE;
        @(posedge HCLK); #4;
        checks++;
        if (ry !== 1'b0) fail("rst_mid_pre_ready", ry, 1'b0);
        rst3_n = 1'b0;
        #1;
        checks++;
        if (ry !== 1'b1) fail("rst_mid_ready", ry, 1'b1);
        checks++;
        if (rsp !== 1'b0) fail("rst_mid_resp", rsp, 1'b0);
        checks++;
        if (rdata !== 32'h0) fail("rst_mid_rdata", rdata, 32'h0);
        @(negedge HCLK);
        rst3_n = 1'b1;
        @(posedge HCLK); #1;
        issue(HTRANS_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'h0, 3, HRESP_OKAY, 32'h11111111);
        issue(HTRANS_NONSEQ, 1'b0, 32'h0, HSIZE_WORD, 32'h0, 3, HRESP_OKAY, 32'h5A5A5A5A);
        idle();

        repeat (2) @(posedge HCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
